// File: rtl/pattern_sig_pkg.sv
// Shared types and defaults for the pattern/signature engine.
// Holds the FSM state encoding plus the default MISR polynomial and seed.
package pattern_sig_pkg;
   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
   localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
   localparam logic [31:0] DEF_SEED = 32'h0000_0000;
endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: shift left, fold in POLY on MSB, xor the response.
// One-cycle update when en; seed_load has priority over en; no backpressure.
module misr_reg
   import pattern_sig_pkg::*;
#(
   parameter int              SIG_W = 32,
   parameter int              OUT_W = 26,
   parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [SIG_W-1:0] seed,
   input  logic             en,
   input  logic [OUT_W-1:0] din,
   output logic [SIG_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= seed;
      end else if (seed_load) begin
         q <= seed;
      end else if (en) begin
         q <= {q[SIG_W-2:0], 1'b0} ^ (q[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
      end
   end

endmodule

// File: rtl/pattern_sig_engine.sv
// Applies stored patterns to a CUT and compresses its responses into a MISR signature.
// Each pattern takes SETTLE+1 cycles; start/load are ignored while a run is in progress.
module pattern_sig_engine
   import pattern_sig_pkg::*;
#(
   parameter int              IN_W   = 60,
   parameter int              OUT_W  = 26,
   parameter int              DEPTH  = 8,
   parameter int              SETTLE = 1,
   parameter int              SIG_W  = 32,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
   parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED),
   localparam int             AW     = $clog2(DEPTH),
   localparam int             CW     = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [IN_W-1:0]  load_data,
   input  logic             start,
   input  logic [CW-1:0]    pat_cnt,
   input  logic [SIG_W-1:0] golden_sig,
   output logic [IN_W-1:0]  cut_in,
   input  logic [OUT_W-1:0] cut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] sig,
   output logic [AW-1:0]    cur_index
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t          state;
   logic [CW-1:0]   cnt_lat;
   logic [SW-1:0]   settle_cnt;
   logic [IN_W-1:0] mem [DEPTH];

   logic            running;
   logic            accept;
   logic            last_pat;
   logic [CW-1:0]   cnt_sat;

   assign running  = (state == APPLY) || (state == SAMPLE);
   assign accept   = ((state == IDLE) || (state == DONE)) && start;
   assign cnt_sat  = (pat_cnt > CW'(DEPTH)) ? CW'(DEPTH) : pat_cnt;
   assign last_pat = ({1'b0, cur_index} == (cnt_lat - CW'(1)));

   // Pattern storage is deliberately outside the reset domain so it survives rst.
   always_ff @(posedge clk) begin
      if (load_en && !running) begin
         mem[load_addr] <= load_data;
      end
   end

   // The write lock above keeps mem[cur_index] stable for the whole pattern.
   assign cut_in = running ? mem[cur_index] : '0;
   assign pass   = done && (sig == golden_sig);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cur_index  <= '0;
         cnt_lat    <= '0;
         settle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  cur_index  <= '0;
                  cnt_lat    <= cnt_sat;
                  settle_cnt <= '0;
                  if (cnt_sat == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= APPLY;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end
            end
            APPLY: begin
               if (settle_cnt == SW'(SETTLE - 1)) begin
                  settle_cnt <= '0;
                  state      <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            SAMPLE: begin
               if (last_pat) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cur_index <= cur_index + 1'b1;
                  state     <= APPLY;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   misr_reg #(
      .SIG_W (SIG_W),
      .OUT_W (OUT_W),
      .POLY  (POLY)
   ) u_misr (
      .clk       (clk),
      .rst       (rst),
      .seed_load (accept),
      .seed      (SEED),
      .en        (state == SAMPLE),
      .din       (cut_out),
      .q         (sig)
   );

endmodule

// File: tb/tb_pattern_sig_engine.sv
// Directed bench for pattern_sig_engine with an 8-bit MISR (POLY 8'h1D) and 4-bit CUT response.
module tb_pattern_sig_engine;

   logic       clk;
   logic       rst;
   logic       load_en;
   logic [2:0] load_addr;
   logic [7:0] load_data;
   logic       start;
   logic [3:0] pat_cnt;
   logic [7:0] golden_sig;
   logic [7:0] cut_in;
   logic [3:0] cut_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] sig;
   logic [2:0] cur_index;

   logic [3:0] co_tab [8];
   int         n_chk;
   int         n_fail;

   pattern_sig_engine #(
      .IN_W   (8),
      .OUT_W  (4),
      .DEPTH  (8),
      .SETTLE (1),
      .SIG_W  (8),
      .POLY   (8'h1D),
      .SEED   (8'h00)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .start      (start),
      .pat_cnt    (pat_cnt),
      .golden_sig (golden_sig),
      .cut_in     (cut_in),
      .cut_out    (cut_out),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .sig        (sig),
      .cur_index  (cur_index)
   );

   // CUT model: response chosen per pattern from a table.
   assign cut_out = co_tab[cur_index];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [2:0] a, input logic [7:0] d);
      load_addr = a;
      load_data = d;
      load_en   = 1'b1;
      step();
      load_en   = 1'b0;
   endtask

   task automatic do_start(input logic [3:0] n);
      pat_cnt = n;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   task automatic set_co(input logic [3:0] v);
      for (int i = 0; i < 8; i++) co_tab[i] = v;
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      rst        = 1'b1;
      load_en    = 1'b0;
      load_addr  = '0;
      load_data  = '0;
      start      = 1'b0;
      pat_cnt    = '0;
      golden_sig = '0;
      set_co(4'h0);

      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sig", sig, 8'h00);
      chk("rst_cut_in", cut_in, 8'h00);
      chk("rst_index", cur_index, 0);
      step();
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 8; i++) load(3'(i), 8'(i));

      // Two patterns, constant response 1.
      set_co(4'h1);
      golden_sig = 8'h03;
      do_start(4'd2);
      chk("s1_busy", busy, 1);
      step();
      step();
      chk("s1_sig_first", sig, 8'h01);
      step();
      chk("s1_not_done_e3", done, 0);
      step();
      chk("s1_done_e4", done, 1);
      chk("s1_sig_final", sig, 8'h03);
      chk("s1_pass", pass, 1);
      chk("s1_busy_off", busy, 0);
      golden_sig = 8'h04;
      #1;
      chk("s1_pass_bad_golden", pass, 0);

      // Zero patterns: straight to DONE.
      golden_sig = 8'h00;
      do_start(4'd0);
      chk("s2_done", done, 1);
      chk("s2_busy", busy, 0);
      chk("s2_sig", sig, 8'h00);
      chk("s2_pass", pass, 1);
      step();
      step();
      chk("s2_busy_still0", busy, 0);
      chk("s2_done_level", done, 1);

      // Polynomial feedback: 08 -> 10 -> 20 -> 40 -> 80 -> 1D.
      set_co(4'h0);
      co_tab[0] = 4'h8;
      golden_sig = 8'h1D;
      do_start(4'd6);
      repeat (10) step();
      chk("s3_sig_80", sig, 8'h80);
      chk("s3_busy", busy, 1);
      step();
      step();
      chk("s3_done", done, 1);
      chk("s3_sig_1d", sig, 8'h1D);
      chk("s3_pass", pass, 1);
      repeat (3) step();
      chk("s3_sig_hold", sig, 8'h1D);

      // start and load_en during a run are ignored.
      set_co(4'h0);
      do_start(4'd3);
      step();
      start     = 1'b1;
      pat_cnt   = 4'd8;
      load_en   = 1'b1;
      load_addr = 3'd0;
      load_data = 8'hAA;
      step();
      start   = 1'b0;
      load_en = 1'b0;
      chk("s4_cut_in_idx1", cut_in, 8'h01);
      repeat (3) step();
      chk("s4_not_done_e5", done, 0);
      step();
      chk("s4_done_e6", done, 1);
      do_start(4'd1);
      chk("s4_mem0_kept", cut_in, 8'h00);
      step();
      step();
      chk("s4_readback_done", done, 1);

      // load and start in the same cycle: run sees the new word.
      load_addr = 3'd0;
      load_data = 8'h5A;
      load_en   = 1'b1;
      do_start(4'd1);
      load_en = 1'b0;
      chk("s11_new_word", cut_in, 8'h5A);
      step();
      step();
      chk("s11_done", done, 1);
      chk("s11_cut_in_idle", cut_in, 8'h00);
      load(3'd0, 8'h00);

      // Reset during the third APPLY aborts the run.
      set_co(4'h1);
      do_start(4'd4);
      repeat (4) step();
      chk("s5_third_apply", cut_in, 8'h02);
      chk("s5_sig_pre", sig, 8'h03);
      #2;
      rst = 1'b1;
      #1;
      chk("s5_rst_busy", busy, 0);
      chk("s5_rst_done", done, 0);
      chk("s5_rst_sig", sig, 8'h00);
      chk("s5_rst_cut_in", cut_in, 8'h00);
      step();
      rst = 1'b0;
      step();
      chk("s5_no_done", done, 0);
      do_start(4'd1);
      step();
      chk("s5_new_not_done", done, 0);
      step();
      chk("s5_new_done", done, 1);
      chk("s5_new_sig", sig, 8'h01);

      // Full memory sweep, two cycles per pattern.
      set_co(4'h0);
      do_start(4'd8);
      for (int c = 0; c < 16; c++) begin
         chk($sformatf("s6_cut_in_c%0d", c), cut_in, 8'(c / 2));
         step();
      end
      chk("s6_done", done, 1);
      chk("s6_cut_in_zero", cut_in, 8'h00);
      chk("s6_index_last", cur_index, 7);
      do_start(4'd0);
      chk("s6_index_wrap", cur_index, 0);

      // pat_cnt above DEPTH saturates to DEPTH.
      do_start(4'd9);
      repeat (15) step();
      chk("sat_not_done_e15", done, 0);
      step();
      chk("sat_done_e16", done, 1);
      chk("sat_index", cur_index, 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_sig_engine.md
PATTERN_SIG_ENGINE -- requirements
Module: pattern_sig_engine

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- IN_W, 60, width of stimulus bus to circuit under test (CUT)
- OUT_W, 26, width of CUT response bus; OUT_W <= SIG_W
- DEPTH, 8, pattern memory entries
- SETTLE, 1, cycles each pattern is held before sampling; >= 1
- SIG_W, 32, MISR width
- POLY, 32'h04C11DB7, MISR feedback polynomial
- SEED, 0, MISR value at start of each run
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst, in, 1, asynchronous, active-high reset
- load_en, in, 1, write load_data into memory at load_addr
- load_addr, in, clog2(DEPTH), write address
- load_data, in, IN_W, pattern word
- start, in, 1, begin a run
- pat_cnt, in, clog2(DEPTH)+1, patterns to apply, 0..DEPTH
- golden_sig, in, SIG_W, expected signature
- cut_in, out, IN_W, stimulus to CUT
- cut_out, in, OUT_W, CUT response
- busy, out, 1, run in progress
- done, out, 1, run complete (level)
- pass, out, 1, sig == golden_sig, valid while done
- sig, out, SIG_W, current MISR value
- cur_index, out, clog2(DEPTH), pattern being applied

Function
REQ-003 FSM SHALL have states IDLE, APPLY, SAMPLE, DONE.
REQ-004 IDLE or DONE with start=1: sig<=SEED, cur_index<=0, pat_cnt latched; latched 0 -> DONE, else -> APPLY.
REQ-005 APPLY SHALL drive cut_in = mem[cur_index] and hold SETTLE cycles (settle counter), then -> SAMPLE.
REQ-006 SAMPLE SHALL update sig <= {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended cut_out, in one cycle.
REQ-007 After SAMPLE: cur_index == latched_cnt-1 -> DONE; else cur_index+1, -> APPLY.
REQ-008 For N>0 patterns, DONE SHALL be entered N*(SETTLE+1) edges after the accepting edge.
REQ-009 busy=1 in APPLY/SAMPLE only; done=1 in DONE only; pass = done & (sig == golden_sig), combinational on golden_sig.
REQ-010 start while busy SHALL be ignored; load_en while busy SHALL be ignored (memory unchanged).
REQ-011 load_en with start in the same cycle from IDLE/DONE: write completes; the run uses the new word.
REQ-012 pat_cnt > DEPTH SHALL be saturated to DEPTH when latched.
REQ-013 cut_in SHALL be all-zero outside APPLY/SAMPLE; in SAMPLE it holds the APPLY value.
REQ-014 sig SHALL hold its final value in DONE until the next accepted start.

Reset
REQ-015 rst=1 SHALL asynchronously force: state IDLE, sig=SEED, cur_index=0, settle counter 0, busy=0, done=0, cut_in=0.
REQ-016 Pattern memory SHALL NOT be reset; contents survive rst.
REQ-017 rst mid-run SHALL abort; no done pulse; the next start begins a fresh run.

Structure
REQ-018 Shared package pattern_sig_pkg SHALL hold the state enum, default POLY and SEED constants.
REQ-019 MISR SHALL be a sub-module misr_reg (params SIG_W, OUT_W, POLY; ports clk, rst, seed_load, seed, en, din, q).

Verification (SIG_W=8, POLY=8'h1D, SEED=0, OUT_W=4, SETTLE=1, DEPTH=8)
REQ-020 Bench SHALL cover these scenarios:
- pat_cnt=2, cut_out=4'h1 constant -> sig 8'h01 then 8'h03; done on edge 4 after start; golden 8'h03 -> pass=1.
- pat_cnt=0, start -> DONE on accepting edge, busy never 1, sig=8'h00, golden 8'h00 -> pass=1.
- sig=8'h80 before SAMPLE, cut_out=0 -> sig=8'h1D.
- start and load_en pulsed during run -> run length unchanged, memory readback unchanged.
- rst asserted during 3rd APPLY -> busy=0, done=0, sig=SEED immediately; new start with pat_cnt=1 -> done after 2 edges.
- pat_cnt=8 with mem[i]=i -> cut_in steps 0..7 with two cycles each; cur_index wraps to 0 on next start.
